// File: rtl/dm_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Optional alignment checking is enabled by defining DM_ARB_ALIGN_CHECK_EN.
package dm_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  localparam logic MST_CPU = 1'b0;
  localparam logic MST_AUX = 1'b1;

  // A word access is misaligned when either byte-offset bit is set
  function automatic logic is_misaligned(input logic [1:0] byte_off);
    return byte_off != 2'b00;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin picker. On a tie the master that did
// not win last time is chosen, so continuous contention alternates grants.
module rr_arb2
  import dm_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_gnt,
  output logic       gnt_valid,
  output logic       gnt_id
);

  // Pick a winner among the active requests, favouring the one not served last
  always_comb begin
    gnt_valid = 1'b0;
    gnt_id    = MST_CPU;
    case (req)
      2'b01: begin
        gnt_valid = 1'b1;
        gnt_id    = MST_CPU;
      end
      2'b10: begin
        gnt_valid = 1'b1;
        gnt_id    = MST_AUX;
      end
      2'b11: begin
        gnt_valid = 1'b1;
        gnt_id    = ~last_gnt;
      end
      default: begin
        gnt_valid = 1'b0;
        gnt_id    = MST_CPU;
      end
    endcase
  end

endmodule

// File: rtl/dm_arbiter.sv
// Two-master scheduler in front of the single-port data memory.
// Each granted request takes IDLE -> ACCESS -> DONE: the memory is driven for
// one cycle in ACCESS and the winner sees a one-cycle ack in DONE.
// Define DM_ARB_ALIGN_CHECK_EN to reject misaligned accesses with err=1.
module dm_arbiter
  import dm_arb_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int WORD_IDX_HI = 11
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [DATA_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [DATA_W-1:0] m0_pc,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_err,

  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [DATA_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic [DATA_W-1:0] m1_pc,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_err,

  output logic              dm_we,
  output logic [DATA_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_din,
  output logic [DATA_W-1:0] dm_wpc,
  input  logic [DATA_W-1:0] dm_dout,

  output logic              busy,
  output logic              gnt_id
);

  if (WORD_IDX_HI < 2 || WORD_IDX_HI >= DATA_W) begin : g_bad_cfg
    $error("dm_arbiter: WORD_IDX_HI must lie in [2, DATA_W-1]");
  end

  state_e            state_q, state_d;
  logic              last_gnt_q, last_gnt_d;
  logic              gnt_id_q, gnt_id_d;
  logic              req_we_q, req_we_d;
  logic [DATA_W-1:0] req_addr_q, req_addr_d;
  logic [DATA_W-1:0] req_wdata_q, req_wdata_d;
  logic [DATA_W-1:0] req_pc_q, req_pc_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic              misalign;
`ifdef DM_ARB_ALIGN_CHECK_EN
  logic              misalign_q, misalign_d;
  assign misalign = misalign_q;
`else
  assign misalign = 1'b0;
`endif

  logic              arb_valid;
  logic              arb_id;
  logic              sel_we;
  logic [DATA_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [DATA_W-1:0] sel_pc;
  logic              in_access;
  logic              in_done;

  rr_arb2 u_rr_arb2 (
    .req       ({m1_req, m0_req}),
    .last_gnt  (last_gnt_q),
    .gnt_valid (arb_valid),
    .gnt_id    (arb_id)
  );

  assign sel_we    = (arb_id == MST_AUX) ? m1_we    : m0_we;
  assign sel_addr  = (arb_id == MST_AUX) ? m1_addr  : m0_addr;
  assign sel_wdata = (arb_id == MST_AUX) ? m1_wdata : m0_wdata;
  assign sel_pc    = (arb_id == MST_AUX) ? m1_pc    : m0_pc;

  // Sequence one access at a time: latch the winner in IDLE, capture read data in ACCESS
  always_comb begin
    state_d     = state_q;
    last_gnt_d  = last_gnt_q;
    gnt_id_d    = gnt_id_q;
    req_we_d    = req_we_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    req_pc_d    = req_pc_q;
    rdata_d     = rdata_q;
`ifdef DM_ARB_ALIGN_CHECK_EN
    misalign_d  = misalign_q;
`endif
    case (state_q)
      IDLE: begin
        if (arb_valid) begin
          state_d     = ACCESS;
          gnt_id_d    = arb_id;
          last_gnt_d  = arb_id;
          req_we_d    = sel_we;
          req_addr_d  = sel_addr;
          req_wdata_d = sel_wdata;
          req_pc_d    = sel_pc;
`ifdef DM_ARB_ALIGN_CHECK_EN
          misalign_d  = is_misaligned(sel_addr[1:0]);
`endif
        end
      end
      ACCESS: begin
        state_d = DONE;
        if (misalign) begin
          rdata_d = '0;
        end else if (!req_we_q) begin
          rdata_d = dm_dout;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and request registers; reset abandons any in-flight access
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      last_gnt_q  <= MST_AUX;
      gnt_id_q    <= MST_CPU;
      req_we_q    <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      req_pc_q    <= '0;
      rdata_q     <= '0;
`ifdef DM_ARB_ALIGN_CHECK_EN
      misalign_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      last_gnt_q  <= last_gnt_d;
      gnt_id_q    <= gnt_id_d;
      req_we_q    <= req_we_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      req_pc_q    <= req_pc_d;
      rdata_q     <= rdata_d;
`ifdef DM_ARB_ALIGN_CHECK_EN
      misalign_q  <= misalign_d;
`endif
    end
  end

  assign in_access = (state_q == ACCESS);
  assign in_done   = (state_q == DONE);

  assign dm_we   = in_access && req_we_q && !misalign;
  assign dm_addr = in_access ? req_addr_q  : '0;
  assign dm_din  = in_access ? req_wdata_q : '0;
  assign dm_wpc  = in_access ? req_pc_q    : '0;

  assign m0_ack   = in_done && (gnt_id_q == MST_CPU);
  assign m1_ack   = in_done && (gnt_id_q == MST_AUX);
  assign m0_rdata = rdata_q;
  assign m1_rdata = rdata_q;
  assign m0_err   = m0_ack && misalign;
  assign m1_err   = m1_ack && misalign;

  assign busy   = (state_q != IDLE);
  assign gnt_id = gnt_id_q;

endmodule

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
- Two-requester scheduler in front of the single-port 1024-word data memory.
- Master 0 is the CPU load/store stage; master 1 is a secondary port such as a loader or debug probe.
- The block serialises accesses, arbitrates round-robin, drives the memory's write strobe, address, data and write-PC lines, and returns registered read data with a one-cycle ack pulse.

Parameters:
- DATA_W, 32, width of data, address and PC buses.
- WORD_IDX_HI, 11, top address bit used as word index; bits [WORD_IDX_HI:2] select the word.

Ports:
- clk  in  1  system clock, all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- m0_req  in  1  master 0 request; held high until m0_ack.
- m0_we  in  1  master 0 write (1) / read (0).
- m0_addr  in  DATA_W  master 0 byte address.
- m0_wdata  in  DATA_W  master 0 write data.
- m0_pc  in  DATA_W  PC of the master 0 instruction, forwarded for the write trace.
- m0_ack  out  1  one-cycle completion pulse.
- m0_rdata  out  DATA_W  read data, valid while m0_ack=1.
- m0_err  out  1  error flag, valid with m0_ack (only with the optional feature).
- m1_req, m1_we, m1_addr, m1_wdata, m1_pc, m1_ack, m1_rdata, m1_err: same as master 0.
- dm_we  out  1  memory write strobe.
- dm_addr  out  DATA_W  memory address.
- dm_din  out  DATA_W  memory write data.
- dm_wpc  out  DATA_W  PC forwarded to the memory write trace.
- dm_dout  in  DATA_W  combinational memory read data.
- busy  out  1  high in any state other than IDLE.
- gnt_id  out  1  master currently owning the access (0/1).

Behaviour:
- Reset:
  - state=IDLE, last_gnt=1 (so master 0 wins first).
  - All acks, errs and dm_we = 0; all data/address outputs = 0; busy=0, gnt_id=0.
- States and transitions:
  - IDLE -> ACCESS when any req is high; else stay in IDLE.
  - ACCESS -> DONE unconditionally.
  - DONE -> IDLE unconditionally.
- IDLE:
  - Sample both reqs.
  - If one is high, grant it.
  - If both are high, grant !last_gnt.
  - Latch winner's we/addr/wdata/pc into a request register, set gnt_id and last_gnt.
- ACCESS (exactly one cycle):
  - dm_addr, dm_din and dm_wpc come from the request register.
  - dm_we = latched we.
  - For a read, capture dm_dout into the read-data register at the end of this cycle.
  - For a write, dm_rdata register is unchanged.
- DONE:
  - Assert the winner's ack for exactly one cycle; the other master's ack stays 0.
  - rdata is valid with ack; it is meaningful for reads and don't-care for writes.
  - dm_we=0 in this state.
- Latency: request sampled in IDLE at cycle N, memory access in cycle N+1, ack in cycle N+2.
  - Peak throughput is one access per 3 cycles.
- Requester rule: keep req and its fields stable from assertion until ack, and drop or renew req in the cycle after ack.
  - A req still high in the IDLE cycle after DONE is treated as a new request.
  - Fields changed while a request is pending are ignored, because the block latches them at grant.
- dm_we is only ever high in ACCESS, so at most one write per granted request.
- Round-robin fairness: with both reqs held continuously, grants alternate 0,1,0,1.
- Simultaneous req arrival while busy: the new req waits and is arbitrated in the next IDLE.
- Reset asserted mid-operation (ACCESS or DONE):
  - Next state is IDLE.
  - The pending ack is never issued and no further dm_we is issued.
  - A write already strobed in that cycle is not undone.
- Addresses above WORD_IDX_HI are passed through unchanged; memory wrap-around is the memory's concern.

Optional Feature:
- Macro DM_ARB_ALIGN_CHECK_EN.
- Defined:
  - In IDLE, a granted request with addr[1:0]!=0 is flagged misaligned.
  - In ACCESS, dm_we is forced to 0, so no memory write occurs.
  - In DONE, ack is issued with err=1 and rdata=0.
  - Aligned requests give err=0.
- Undefined:
  - m0_err and m1_err are tied to 0.
  - addr[1:0] is ignored and passed through.

Decomposition:
- Package dm_arb_pkg holds:
  - state encoding: IDLE=2'd0, ACCESS=2'd1, DONE=2'd2;
  - master-id constants MST_CPU=1'b0, MST_AUX=1'b1.
- Sub-module rr_arb2: combinational two-way round-robin picker.
  - Inputs: req[1:0], last_gnt.
  - Outputs: gnt_valid, gnt_id.

Test Plan:
- m0 write addr=0x0000_0010, wdata=0xDEAD_BEEF, pc=0x3000 -> dm_we=1 for exactly one cycle N+1 with dm_addr=0x10, dm_wpc=0x3000; m0_ack at N+2.
- m0 read addr=0x10 after that write -> m0_ack at N+2 with m0_rdata=0xDEAD_BEEF; m1_ack stays 0.
- Both reqs held high from reset for 4 grants -> gnt_id sequence 0,1,0,1; each ack spaced 3 cycles.
- m1 write granted, reset asserted during ACCESS -> state IDLE next cycle, m1_ack never asserts, busy=0.
- m1 reads addr=0x20 while m0 req rises during m1's ACCESS -> m1 acked first, m0 granted in the following IDLE.
- With DM_ARB_ALIGN_CHECK_EN, m0 write addr=0x12 -> dm_we stays 0, m0_ack=1 with m0_err=1 and m0_rdata=0; a read of 0x10 returns the prior value.
